// File: rtl/rv_wb_pkg.sv
// Shared types and sizing helpers for the Wishbone master arbiter.
package rv_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_arb_state_t;

  function automatic int sel_width(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int idx_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  function automatic int cnt_width(input int timeout_cycles);
    return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/rv_wb_arbiter_if.sv
// Channel-side req/ack bundle plus the Wishbone master bus of the arbiter.
interface rv_wb_arbiter_if #(
  parameter int CHANNELS   = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  import rv_wb_pkg::*;

  localparam int SEL_WIDTH = sel_width(DATA_WIDTH);

  logic [CHANNELS-1:0]            i_ch_req;
  logic [CHANNELS-1:0]            i_ch_we;
  logic [CHANNELS*ADDR_WIDTH-1:0] i_ch_addr;
  logic [CHANNELS*DATA_WIDTH-1:0] i_ch_wdata;
  logic [CHANNELS*SEL_WIDTH-1:0]  i_ch_sel;
  logic [CHANNELS-1:0]            o_ch_ack;
  logic [CHANNELS-1:0]            o_ch_err;
  logic [DATA_WIDTH-1:0]          o_ch_rdata;

  logic [ADDR_WIDTH-1:0]          o_wb_adr;
  logic [DATA_WIDTH-1:0]          o_wb_dat;
  logic [DATA_WIDTH-1:0]          i_wb_dat;
  logic                           o_wb_we;
  logic [SEL_WIDTH-1:0]           o_wb_sel;
  logic                           o_wb_stb;
  logic                           o_wb_cyc;
  logic                           i_wb_ack;
  logic                           i_wb_err;

  // Arbiter side.
  modport master (
    input  i_ch_req, i_ch_we, i_ch_addr, i_ch_wdata, i_ch_sel,
    output o_ch_ack, o_ch_err, o_ch_rdata,
    output o_wb_adr, o_wb_dat, o_wb_we, o_wb_sel, o_wb_stb, o_wb_cyc,
    input  i_wb_dat, i_wb_ack, i_wb_err
  );

  // Requesters plus the Wishbone slave.
  modport slave (
    output i_ch_req, i_ch_we, i_ch_addr, i_ch_wdata, i_ch_sel,
    input  o_ch_ack, o_ch_err, o_ch_rdata,
    input  o_wb_adr, o_wb_dat, o_wb_we, o_wb_sel, o_wb_stb, o_wb_cyc,
    output i_wb_dat, i_wb_ack, i_wb_err
  );

endinterface

// File: rtl/rv_wb_arb_pick.sv
// Combinational channel picker: fixed lowest-index priority or round-robin
// starting after the last granted channel.
module rv_wb_arb_pick
  import rv_wb_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int ROUND_ROBIN = 0,
  localparam int GW         = idx_width(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [GW-1:0]       last_grant,
  output logic [GW-1:0]       grant,
  output logic                any_req
);

  assign any_req = |req;

  if (CHANNELS == 1) begin : g_single
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant;
    assign grant = '0;
  end else begin : g_multi
    always_comb begin
      int base;
      int idx;
      logic found;
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      grant = '0;
      found = 1'b0;
      idx   = 0;
      base  = (ROUND_ROBIN != 0) ? int'(last_grant) + 1 : 0;
      for (int i = 0; i < CHANNELS; i++) begin
        idx = (base + i) % CHANNELS;
        if (!found && req[idx]) begin
          grant = GW'(idx);
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rv_wb_arbiter.sv
// N-channel Wishbone classic master arbiter: registers the winning request,
// runs one framed cyc/stb transfer and returns a one-cycle ack/err pulse.
module rv_wb_arbiter
  import rv_wb_pkg::*;
#(
  parameter int CHANNELS       = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ROUND_ROBIN    = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  rv_wb_arbiter_if.master bus
);

  localparam int SEL_WIDTH = sel_width(DATA_WIDTH);
  localparam int GW        = idx_width(CHANNELS);
  localparam int CNT_W     = cnt_width(TIMEOUT_CYCLES);
  localparam bit TO_EN     = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  wb_arb_state_t         state_q, state_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [GW-1:0]         last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic                  we_q, we_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_flag_q, err_flag_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [GW-1:0]         pick;
  logic                  any_req;
  logic                  timeout;

  rv_wb_arb_pick #(
    .CHANNELS    (CHANNELS),
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_pick (
    .req        (bus.i_ch_req),
    .last_grant (last_grant_q),
    .grant      (pick),
    .any_req    (any_req)
  );

  always_comb begin
    int g;
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    we_d         = we_q;
    sel_d        = sel_q;
    rdata_d      = rdata_q;
    err_flag_d   = err_flag_q;
    cnt_d        = cnt_q;
    g            = int'(pick);
    timeout      = TO_EN && (cnt_q == TO_LAST);

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d      = pick;
          last_grant_d = pick;
          adr_d        = bus.i_ch_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
          dat_d        = bus.i_ch_wdata[g*DATA_WIDTH +: DATA_WIDTH];
          sel_d        = bus.i_ch_sel[g*SEL_WIDTH +: SEL_WIDTH];
          we_d         = bus.i_ch_we[g];
          cnt_d        = '0;
          state_d      = BUS;
        end
      end
      BUS: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.i_wb_ack || bus.i_wb_err || timeout) begin
          // A watchdog abort returns zero rather than whatever floats on the bus.
          rdata_d    = timeout ? '0 : bus.i_wb_dat;
          err_flag_d = bus.i_wb_err | timeout;
          state_d    = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(CHANNELS - 1);
      adr_q        <= '0;
      dat_q        <= '0;
      we_q         <= 1'b0;
      sel_q        <= '0;
      rdata_q      <= '0;
      err_flag_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      we_q         <= we_d;
      sel_q        <= sel_d;
      rdata_q      <= rdata_d;
      err_flag_q   <= err_flag_d;
      cnt_q        <= cnt_d;
    end
  end

  // Framing decodes straight from state so reset drops cyc/stb/ack without an edge.
  assign bus.o_wb_cyc   = (state_q == BUS);
  assign bus.o_wb_stb   = (state_q == BUS);
  assign bus.o_wb_adr   = adr_q;
  assign bus.o_wb_dat   = dat_q;
  assign bus.o_wb_we    = we_q;
  assign bus.o_wb_sel   = sel_q;
  assign bus.o_ch_rdata = rdata_q;
  assign bus.o_ch_ack   = (state_q == RESP) ? (CHANNELS'(1) << grant_q) : '0;
  assign bus.o_ch_err   = bus.o_ch_ack & {CHANNELS{err_flag_q}};

endmodule

// File: tb/tb_rv_wb_arbiter.sv
// Directed bench: a 2-channel fixed-priority arbiter with an 8-cycle watchdog
// and a 3-channel round-robin arbiter share one clock and reset.
module tb_rv_wb_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rv_wb_arbiter_if #(.CHANNELS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) ifa ();
  rv_wb_arbiter_if #(.CHANNELS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32)) ifb ();

  rv_wb_arbiter #(
    .CHANNELS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .ROUND_ROBIN(0), .TIMEOUT_CYCLES(8)
  ) dut_a (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (ifa)
  );

  rv_wb_arbiter #(
    .CHANNELS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .ROUND_ROBIN(1), .TIMEOUT_CYCLES(255)
  ) dut_b (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (ifb)
  );

  // Slave models: manual ack/err, or a zero-wait slave that acks whenever cyc is up.
  logic a_ack, a_err, a_auto, b_auto;
  assign ifa.i_wb_ack = a_ack | (a_auto & ifa.o_wb_cyc);
  assign ifa.i_wb_err = a_err;
  assign ifb.i_wb_ack = b_auto & ifb.o_wb_cyc;
  assign ifb.i_wb_err = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until dut_b pulses an ack, at most 8 cycles.
  task automatic wait_ack_b();
    for (int k = 0; k < 8; k++) begin
      tick();
      if (ifb.o_ch_ack != 3'b000) break;
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    a_ack = 1'b0; a_err = 1'b0; a_auto = 1'b0; b_auto = 1'b0;
    ifa.i_ch_req = '0; ifa.i_ch_we = '0; ifa.i_ch_addr = '0;
    ifa.i_ch_wdata = '0; ifa.i_ch_sel = '0; ifa.i_wb_dat = '0;
    ifb.i_ch_req = '0; ifb.i_ch_we = '0; ifb.i_ch_addr = '0;
    ifb.i_ch_wdata = '0; ifb.i_ch_sel = '0; ifb.i_wb_dat = '0;

    repeat (2) tick();
    check("rst_cyc",   ifa.o_wb_cyc, 1'b0);
    check("rst_stb",   ifa.o_wb_stb, 1'b0);
    check("rst_ack",   ifa.o_ch_ack, 2'b00);
    check("rst_rdata", ifa.o_ch_rdata, 32'h0);
    check("rst_adr",   ifa.o_wb_adr, 32'h0);
    rst_n = 1'b1;
    tick();

    // Single read on channel 1, slave acks two cycles after stb.
    ifa.i_ch_addr  = {32'h0000_0100, 32'h0};
    ifa.i_ch_sel   = 8'hFF;
    ifa.i_ch_we    = 2'b00;
    ifa.i_wb_dat   = 32'hDEAD_BEEF;
    ifa.i_ch_req   = 2'b10;
    tick();
    check("rd_cyc1", ifa.o_wb_cyc, 1'b1);
    check("rd_stb1", ifa.o_wb_stb, 1'b1);
    check("rd_adr",  ifa.o_wb_adr, 32'h0000_0100);
    check("rd_we",   ifa.o_wb_we, 1'b0);
    tick();
    check("rd_cyc2", ifa.o_wb_cyc, 1'b1);
    tick();
    check("rd_cyc3", ifa.o_wb_cyc, 1'b1);
    a_ack = 1'b1;
    tick();
    check("rd_ack",   ifa.o_ch_ack, 2'b10);
    check("rd_err",   ifa.o_ch_err, 2'b00);
    check("rd_rdata", ifa.o_ch_rdata, 32'hDEAD_BEEF);
    check("rd_cyc_resp", ifa.o_wb_cyc, 1'b0);
    a_ack = 1'b0;
    ifa.i_ch_req = 2'b00;
    tick();
    check("rd_ack_off", ifa.o_ch_ack, 2'b00);

    // Both channels request; fixed priority serves ch0 (write) then ch1.
    ifa.i_ch_addr  = {32'h0000_0200, 32'h0000_0010};
    ifa.i_ch_wdata = {32'h0, 32'h1234_5678};
    ifa.i_ch_sel   = {4'hF, 4'b0011};
    ifa.i_ch_we    = 2'b01;
    ifa.i_wb_dat   = 32'hCAFE_F00D;
    ifa.i_ch_req   = 2'b11;
    a_auto = 1'b1;
    tick();
    check("pri_cyc0", ifa.o_wb_cyc, 1'b1);
    check("pri_adr0", ifa.o_wb_adr, 32'h0000_0010);
    check("pri_we0",  ifa.o_wb_we, 1'b1);
    check("pri_sel0", ifa.o_wb_sel, 4'b0011);
    check("pri_dat0", ifa.o_wb_dat, 32'h1234_5678);
    tick();
    check("pri_ack0", ifa.o_ch_ack, 2'b01);
    ifa.i_ch_req = 2'b10;
    tick();
    check("pri_idle_gap", ifa.o_wb_cyc, 1'b0);
    tick();
    check("pri_cyc1", ifa.o_wb_cyc, 1'b1);
    check("pri_adr1", ifa.o_wb_adr, 32'h0000_0200);
    check("pri_we1",  ifa.o_wb_we, 1'b0);
    tick();
    check("pri_ack1",   ifa.o_ch_ack, 2'b10);
    check("pri_rdata1", ifa.o_ch_rdata, 32'hCAFE_F00D);
    ifa.i_ch_req = 2'b00;
    a_auto = 1'b0;
    tick();

    // Slave raises ack and err together: err wins.
    ifa.i_ch_we  = 2'b00;
    ifa.i_ch_req = 2'b01;
    tick();
    check("ae_cyc", ifa.o_wb_cyc, 1'b1);
    a_ack = 1'b1;
    a_err = 1'b1;
    tick();
    check("ae_ack", ifa.o_ch_ack, 2'b01);
    check("ae_err", ifa.o_ch_err, 2'b01);
    a_ack = 1'b0;
    a_err = 1'b0;
    ifa.i_ch_req = 2'b00;
    tick();

    // Silent slave: watchdog aborts after 8 BUS cycles with zero data.
    ifa.i_wb_dat = 32'hFFFF_0000;
    ifa.i_ch_req = 2'b10;
    tick();
    n = 0;
    while (ifa.o_wb_cyc && n < 20) begin
      n++;
      tick();
    end
    check("to_bus_cycles", 64'(n), 64'd8);
    check("to_ack",   ifa.o_ch_ack, 2'b10);
    check("to_err",   ifa.o_ch_err, 2'b10);
    check("to_rdata", ifa.o_ch_rdata, 32'h0);
    ifa.i_ch_req = 2'b00;
    tick();
    ifa.i_wb_dat = 32'h0BAD_CAFE;
    ifa.i_ch_req = 2'b01;
    a_auto = 1'b1;
    tick();
    tick();
    check("to_next_ack",   ifa.o_ch_ack, 2'b01);
    check("to_next_err",   ifa.o_ch_err, 2'b00);
    check("to_next_rdata", ifa.o_ch_rdata, 32'h0BAD_CAFE);
    ifa.i_ch_req = 2'b00;
    a_auto = 1'b0;
    tick();

    // Round-robin with all three channels requesting continuously.
    ifb.i_ch_addr = {32'h0000_1008, 32'h0000_1004, 32'h0000_1000};
    ifb.i_ch_sel  = 12'hFFF;
    ifb.i_ch_req  = 3'b111;
    b_auto = 1'b1;
    for (int t = 0; t < 6; t++) begin
      wait_ack_b();
      check($sformatf("rr_grant%0d", t), ifb.o_ch_ack, 3'b001 << (t % 3));
    end

    // Serve ch0 alone so the rotation pointer is at 0, then park ch1 in BUS.
    ifb.i_ch_req = 3'b001;
    wait_ack_b();
    check("rr_ch0_only", ifb.o_ch_ack, 3'b001);
    b_auto = 1'b0;
    ifb.i_ch_req = 3'b111;
    tick();
    tick();
    check("rr_park_cyc", ifb.o_wb_cyc, 1'b1);
    check("rr_park_adr", ifb.o_wb_adr, 32'h0000_1004);

    // Reset mid-BUS: cyc/stb must fall without a clock edge.
    rst_n = 1'b0;
    #1;
    check("rst_mid_cyc", ifb.o_wb_cyc, 1'b0);
    check("rst_mid_stb", ifb.o_wb_stb, 1'b0);
    check("rst_mid_ack", ifb.o_ch_ack, 3'b000);
    check("rst_mid_rdata", ifb.o_ch_rdata, 32'h0);
    tick();
    check("rst_hold_ack", ifb.o_ch_ack, 3'b000);
    rst_n = 1'b1;
    tick();
    check("rr_restart_cyc", ifb.o_wb_cyc, 1'b1);
    check("rr_restart_adr", ifb.o_wb_adr, 32'h0000_1000);
    b_auto = 1'b1;
    tick();
    check("rr_restart_ack", ifb.o_ch_ack, 3'b001);
    ifb.i_ch_req = 3'b000;
    b_auto = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rv_wb_arbiter.md
Name: rv_wb_arbiter

Overview:
Parametrised N-channel Wishbone classic master arbiter with registered request capture. Replaces the combinational instruction/data mux in the top level. Core instruction, data and any future ports (debug, DMA) each present a simple req/ack channel. The block serialises these channels onto one Wishbone master. It adds fixed or round-robin priority, proper cyc/stb framing, bus error forwarding and a bus-timeout watchdog.

Parameters:
CHANNELS, 2, number of requesting channels (>=1); channel 0 = data, channel 1 = instruction.
ADDR_WIDTH, 32, address width.
DATA_WIDTH, 32, data width; must be a multiple of 8; SEL_WIDTH = DATA_WIDTH/8.
ROUND_ROBIN, 0, 0 = fixed priority (lowest index wins), 1 = round-robin starting after the last granted channel.
TIMEOUT_CYCLES, 255, BUS-state cycles before a forced error response; 0 disables the watchdog.

Ports:
i_clk  in  1  clock
i_reset_n  in  1  asynchronous active-low reset
i_ch_req  in  CHANNELS  per-channel request, held high until o_ch_ack
i_ch_we  in  CHANNELS  per-channel write enable
i_ch_addr  in  CHANNELS*ADDR_WIDTH  packed addresses, channel k at [k*AW +: AW]
i_ch_wdata  in  CHANNELS*DATA_WIDTH  packed write data
i_ch_sel  in  CHANNELS*SEL_WIDTH  packed byte selects
o_ch_ack  out  CHANNELS  one-cycle completion pulse, onehot or zero
o_ch_err  out  CHANNELS  error qualifier, valid only with o_ch_ack
o_ch_rdata  out  DATA_WIDTH  read data, shared by all channels, valid with o_ch_ack
o_wb_adr  out  ADDR_WIDTH  Wishbone address
o_wb_dat  out  DATA_WIDTH  Wishbone write data
i_wb_dat  in  DATA_WIDTH  Wishbone read data
o_wb_we  out  1  Wishbone write enable
o_wb_sel  out  SEL_WIDTH  Wishbone byte select
o_wb_stb  out  1  Wishbone strobe
o_wb_cyc  out  1  Wishbone cycle
i_wb_ack  in  1  Wishbone acknowledge
i_wb_err  in  1  Wishbone error

Behaviour:
- Clocking and reset:
  - One clock, i_clk. Reset is asynchronous active-low on i_reset_n.
  - Reset drives state = IDLE and clears all outputs to 0, including cyc, stb, acks, errs, rdata, adr, dat, we and sel.
  - Reset also clears last_grant to CHANNELS-1, so round-robin starts at channel 0, and clears the timeout counter.
- FSM states are IDLE, BUS and RESP.
- IDLE:
  - If any i_ch_req is high, pick grant g, register addr/wdata/we/sel of g and last_grant = g, then go to BUS.
  - The next cycle shows o_wb_cyc = o_wb_stb = 1.
  - Latency from req to cyc/stb is 1 cycle.
- Arbitration:
  - Fixed mode: lowest set index wins.
  - Round-robin mode: search starts at last_grant+1, wraps modulo CHANNELS, and takes the first set bit.
  - CHANNELS = 1 degenerates to a pass-through with no rotation logic.
- BUS:
  - cyc, stb, adr, dat, we and sel are held stable. The timeout counter increments every cycle.
  - Leave BUS when i_wb_ack, i_wb_err or a timeout occurs (counter == TIMEOUT_CYCLES-1, only if TIMEOUT_CYCLES != 0).
  - On leaving: drop cyc/stb at the same edge, capture i_wb_dat into o_ch_rdata, set err_flag = i_wb_err | timeout, go to RESP.
  - If ack and err arrive in the same cycle, err wins.
  - On timeout, o_ch_rdata = 0.
- RESP:
  - o_ch_ack[g] = 1 and o_ch_err[g] = err_flag for exactly one cycle, then IDLE.
  - New arbitration is not evaluated in RESP. The requester must deassert req at the edge ending RESP; otherwise the request is re-served as a new transfer.
- Throughput: 3 cycles minimum per transfer (IDLE, BUS, RESP) with a zero-wait slave.
- Request changes: changes on i_ch_* while a transfer is in flight are ignored because all fields are registered. A req from a non-granted channel waits.
- Reads: o_wb_sel and o_wb_dat are driven from the channel values as registered; the block does not force sel for reads.
- Reset mid-transfer: cyc/stb fall asynchronously and no ack is issued. The requester sees no completion and must re-request after reset.
- Timeout counter width is clog2(TIMEOUT_CYCLES+1), minimum 1. The counter clears on entry to BUS.

Decomposition:
- Shared package rv_wb_pkg: state enum wb_arb_state_t {IDLE, BUS, RESP}, and the helper function/constant for SEL_WIDTH.
- Sub-module rv_wb_arb_pick(CHANNELS, ROUND_ROBIN): combinational picker.
  - Inputs: req vector, last_grant.
  - Outputs: grant index, any_req.
  - Verified standalone.

Test Plan:
- Single read, channel 1, addr 0x0000_0100, slave acks 2 cycles after stb with 0xDEADBEEF -> cyc high for 3 cycles, then o_ch_ack = 2'b10 with rdata 0xDEADBEEF and err = 0; cyc/stb low by RESP.
- Simultaneous req on ch0 (write 0x10, data 0x12345678, sel 4'b0011) and ch1, fixed priority -> ch0 served first with we=1, sel=0011; ch1 served next with no idle bus gap beyond IDLE.
- ROUND_ROBIN=1, CHANNELS=3, all reqs held continuously and re-raised after ack -> grant order 0,1,2,0,1,2.
- Slave asserts i_wb_ack and i_wb_err in the same cycle -> o_ch_ack pulse with o_ch_err = 1 on the granted channel.
- TIMEOUT_CYCLES=8, no slave ack -> cyc drops after 8 BUS cycles; ack+err pulse with rdata 0; next req is served normally.
- Assert i_reset_n low during BUS -> cyc/stb/ack go 0 immediately without waiting for a clock edge; after release, round-robin restarts at channel 0.
